cpu_selftest_ctrl: RTL and testbench

- Synthesizable on-chip self-test controller for the mips16_sc core. It replaces hand-written per-instruction benches, such as the slt bench, with one reusable checker.
- Sequence: hold CPU in reset, release it, count cycles until halt or timeout, then read back the data registers through a debug port and compare them against a loaded expected-value table.
- Reports pass/fail, cycle count, first failing entry and mismatch count.

---
 rtl/cpu_selftest_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cpu_selftest_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_selftest_ctrl.sv
// Self-test controller for the mips16_sc core: resets the CPU, lets it run
// until halt or timeout, then reads back data registers through the debug
// port and compares them with a loadable expected-value table.

// One expected-value table entry: enable bit, register number, value.
module cpu_selftest_entry #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_valid,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_val,
  output logic              ent_valid,
  output logic [REG_AW-1:0] ent_reg,
  output logic [DATA_W-1:0] ent_val
);
  // Entry storage; reset invalidates the entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid <= 1'b0;
      ent_reg   <= '0;
      ent_val   <= '0;
    end else if (wr_en) begin
      ent_valid <= wr_valid;
      ent_reg   <= wr_reg;
      ent_val   <= wr_val;
    end
  end
endmodule

module cpu_selftest_ctrl #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int N_CHECKS   = 8,
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 1000,
  localparam int IDX_W     = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1,
  localparam int MC_W      = $clog2(N_CHECKS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               exp_wr_en,
  input  logic [IDX_W-1:0]   exp_wr_idx,
  input  logic               exp_wr_valid,
  input  logic [REG_AW-1:0]  exp_wr_reg,
  input  logic [DATA_W-1:0]  exp_wr_val,
  output logic               cpu_reset,
  output logic               cpu_run,
  input  logic               cpu_halt,
  output logic [REG_AW-1:0]  dbg_reg_addr,
  input  logic [DATA_W-1:0]  dbg_reg_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycles,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [MC_W-1:0]    mismatch_cnt
);
  typedef enum logic [2:0] {IDLE, CPU_RST, RUN, CHK_ADDR, CHK_CMP, DONE} state_t;

  state_t                           state;
  logic [CYCLE_W-1:0]               counter;
  logic [IDX_W-1:0]                 idx;
  logic [N_CHECKS-1:0]              tbl_valid;
  logic [N_CHECKS-1:0][REG_AW-1:0]  tbl_reg;
  logic [N_CHECKS-1:0][DATA_W-1:0]  tbl_val;
  logic                             wr_ok;
  logic [CYCLE_W-1:0]               cnt_inc;
  logic [IDX_W-1:0]                 idx_inc;
  logic                             last;
  logic                             cmp_miss;
  logic [MC_W-1:0]                  mis_next;

  assign wr_ok = exp_wr_en && (state == IDLE || state == DONE);

  genvar g;
  generate
    for (g = 0; g < N_CHECKS; g++) begin : g_ent
      cpu_selftest_entry #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_ent (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_ok && (exp_wr_idx == IDX_W'(g))),
        .wr_valid  (exp_wr_valid),
        .wr_reg    (exp_wr_reg),
        .wr_val    (exp_wr_val),
        .ent_valid (tbl_valid[g]),
        .ent_reg   (tbl_reg[g]),
        .ent_val   (tbl_val[g])
      );
    end
  endgenerate

  // Next-value helpers for the counter, the check index and the mismatch tally.
  always_comb begin
    cnt_inc  = counter + CYCLE_W'(1);
    idx_inc  = idx + IDX_W'(1);
    last     = (idx == IDX_W'(N_CHECKS - 1));
    cmp_miss = (dbg_reg_data != tbl_val[idx]);
    mis_next = mismatch_cnt + MC_W'(cmp_miss);
  end

  // Sequencer. dbg_reg_addr is loaded one step ahead (on entry to CHK_ADDR)
  // so the 1-cycle read data lines up with CHK_CMP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      idx          <= '0;
      cpu_reset    <= 1'b1;
      cpu_run      <= 1'b0;
      dbg_reg_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      cycles       <= '0;
      fail_idx     <= '0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= CPU_RST;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            cycles       <= '0;
            fail_idx     <= '0;
            mismatch_cnt <= '0;
            dbg_reg_addr <= '0;
            cpu_reset    <= 1'b1;
            cpu_run      <= 1'b0;
          end
        end
        CPU_RST: begin
          state     <= RUN;
          counter   <= '0;
          cpu_reset <= 1'b0;
          cpu_run   <= 1'b1;
        end
        RUN: begin
          counter <= cnt_inc;
          if (cpu_halt) begin
            cycles  <= cnt_inc;
            idx     <= '0;
            state   <= CHK_ADDR;
            cpu_run <= 1'b0;
            if (tbl_valid[0]) dbg_reg_addr <= tbl_reg[0];
          end else if (cnt_inc == CYCLE_W'(MAX_CYCLES)) begin
            cycles    <= cnt_inc;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_run   <= 1'b0;
            cpu_reset <= 1'b1;
            state     <= DONE;
          end
        end
        CHK_ADDR: begin
          if (tbl_valid[idx]) begin
            state <= CHK_CMP;
          end else if (last) begin
            pass      <= (mismatch_cnt == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx_inc;
            if (tbl_valid[idx_inc]) dbg_reg_addr <= tbl_reg[idx_inc];
          end
        end
        CHK_CMP: begin
          mismatch_cnt <= mis_next;
          if (cmp_miss && mismatch_cnt == '0) fail_idx <= idx;
          if (last) begin
            pass      <= (mis_next == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx_inc;
            state <= CHK_ADDR;
            if (tbl_valid[idx_inc]) dbg_reg_addr <= tbl_reg[idx_inc];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_selftest_ctrl.sv
// Bench for cpu_selftest_ctrl: a toy CPU (halt after N run cycles, register
// array behind a 1-cycle debug read) plus a table-level reference model.
module tb_cpu_selftest_ctrl;
  localparam int DATA_W = 16, REG_AW = 3, N_CHECKS = 8, CYCLE_W = 16, MAX_CYCLES = 20;
  localparam int IDX_W = 3, MC_W = 4;

  logic               clock = 1'b0;
  logic               reset, start, exp_wr_en, exp_wr_valid;
  logic [IDX_W-1:0]   exp_wr_idx;
  logic [REG_AW-1:0]  exp_wr_reg;
  logic [DATA_W-1:0]  exp_wr_val;
  logic               cpu_reset, cpu_run, cpu_halt;
  logic [REG_AW-1:0]  dbg_reg_addr;
  logic [DATA_W-1:0]  dbg_reg_data;
  logic               busy, done, pass, timeout;
  logic [CYCLE_W-1:0] cycles;
  logic [IDX_W-1:0]   fail_idx;
  logic [MC_W-1:0]    mismatch_cnt;

  cpu_selftest_ctrl #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .N_CHECKS(N_CHECKS),
    .CYCLE_W(CYCLE_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_valid(exp_wr_valid),
    .exp_wr_reg(exp_wr_reg), .exp_wr_val(exp_wr_val),
    .cpu_reset(cpu_reset), .cpu_run(cpu_run), .cpu_halt(cpu_halt),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycles(cycles), .fail_idx(fail_idx), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clock = ~clock;

  // Toy CPU: register file with synchronous debug read, halt on run cycle halt_at.
  logic [DATA_W-1:0] regs [8];
  int run_cnt = 0;
  int halt_at = 0;
  always @(posedge clock) dbg_reg_data <= regs[dbg_reg_addr];
  always @(posedge clock) begin
    if (cpu_reset) run_cnt <= 0;
    else if (cpu_run) run_cnt <= run_cnt + 1;
  end
  assign cpu_halt = cpu_run && (halt_at != 0) && (run_cnt + 1 == halt_at);

  // Reference table contents.
  bit                m_valid [N_CHECKS];
  logic [REG_AW-1:0] m_reg   [N_CHECKS];
  logic [DATA_W-1:0] m_val   [N_CHECKS];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_CHECKS; i++) begin
      m_valid[i] = 1'b0; m_reg[i] = '0; m_val[i] = '0;
    end
  endtask

  task automatic drive_wr(input int i, input int v, input int r, input int val);
    exp_wr_en    = 1'b1;
    exp_wr_idx   = IDX_W'(i);
    exp_wr_valid = (v != 0);
    exp_wr_reg   = REG_AW'(r);
    exp_wr_val   = DATA_W'(val);
    m_valid[i]   = (v != 0);
    m_reg[i]     = REG_AW'(r);
    m_val[i]     = DATA_W'(val);
  endtask

  task automatic wr_entry(input int i, input int v, input int r, input int val);
    drive_wr(i, v, r, val);
    @(negedge clock);
    exp_wr_en = 1'b0;
  endtask

  // One full test run. Called at a negedge; start goes out on the next edge
  // together with any table write the caller has already set up.
  // j counts cycles after the start edge: 0=CPU reset, 1..cyc=run, then checks, lat=done.
  task automatic run_test(input string tag, input int h, input int pulse_j, input int abort_j);
    int cyc, lat, mm, fidx;
    bit to, ps;
    if (h != 0 && h <= MAX_CYCLES) begin
      cyc = h; to = 1'b0; mm = 0; fidx = 0; lat = cyc + 1;
      for (int i = 0; i < N_CHECKS; i++) begin
        lat += m_valid[i] ? 2 : 1;
        if (m_valid[i] && regs[m_reg[i]] !== m_val[i]) begin
          if (mm == 0) fidx = i;
          mm++;
        end
      end
      ps = (mm == 0);
    end else begin
      cyc = MAX_CYCLES; to = 1'b1; mm = 0; fidx = 0; ps = 1'b0; lat = cyc + 1;
    end
    halt_at = h;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0; exp_wr_en = 1'b0;
    for (int j = 0; j <= lat + 2; j++) begin
      chk($sformatf("%s ctl j%0d", tag, j), 32'({cpu_reset, cpu_run, busy, done}),
          32'({(j == 0 || j >= lat), (j >= 1 && j <= cyc), (j < lat), (j >= lat)}));
      start = 1'b0; exp_wr_en = 1'b0;
      if (j == abort_j) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk({tag, " abort"}, {cpu_reset, cpu_run, busy, done, pass, timeout, cycles,
                              fail_idx, mismatch_cnt, dbg_reg_addr}, 32'h8000_0000);
        clear_model();
        return;
      end
      if (j == pulse_j) begin
        start        = 1'b1;
        exp_wr_en    = 1'b1;
        exp_wr_idx   = IDX_W'($urandom_range(0, 1));
        exp_wr_valid = 1'b1;
        exp_wr_reg   = REG_AW'($urandom_range(5, 7));
        exp_wr_val   = DATA_W'($urandom_range(100, 200));
      end
      @(negedge clock);
    end
    chk({tag, " pass"}, 32'(pass), 32'(ps));
    chk({tag, " timeout"}, 32'(timeout), 32'(to));
    chk({tag, " cycles"}, 32'(cycles), 32'(cyc));
    chk({tag, " fail_idx"}, 32'(fail_idx), 32'(fidx));
    chk({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(mm));
    if (to) chk({tag, " no_dbg"}, 32'(dbg_reg_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; exp_wr_en = 1'b0; exp_wr_valid = 1'b0;
    exp_wr_idx = '0; exp_wr_reg = '0; exp_wr_val = '0;
    for (int r = 0; r < 8; r++) regs[r] = '0;
    clear_model();
    repeat (2) @(negedge clock);
    chk("reset state", {cpu_reset, cpu_run, busy, done, pass, timeout, cycles,
                        fail_idx, mismatch_cnt, dbg_reg_addr}, 32'h8000_0000);
    reset = 1'b0;
    @(negedge clock);

    // Two valid entries, correct CPU result, halt on run cycle 5.
    wr_entry(0, 1, 3, 1);
    wr_entry(1, 1, 4, 0);
    regs[3] = 16'd1; regs[4] = 16'd0;
    run_test("t1", 5, -1, -1);
    // One then two wrong registers; first failing index stays 0.
    regs[3] = 16'd0;
    run_test("t2a", 5, -1, -1);
    regs[4] = 16'd7;
    run_test("t2b", 5, -1, -1);
    // No halt: timeout after MAX_CYCLES, no checks.
    run_test("t3", 0, -1, -1);
    // Empty table, halt on cycle 1; halt exactly at the limit.
    wr_entry(0, 0, 3, 1);
    wr_entry(1, 0, 4, 0);
    run_test("t4a", 1, -1, -1);
    run_test("t4b", MAX_CYCLES, -1, -1);
    // start/write during RUN ignored; reset during CHK_CMP aborts and empties table.
    wr_entry(0, 1, 3, 1);
    regs[3] = 16'd1;
    run_test("t5run", 5, 2, -1);
    run_test("t5abort", 3, -1, 5);
    run_test("t5empty", 2, -1, -1);
    // Write and start on the same edge in DONE: new entry is checked.
    regs[5] = 16'd8;
    drive_wr(2, 1, 5, 9);
    run_test("t6", 4, -1, -1);

    // Randomized tables, register contents and halt points.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N_CHECKS; i++)
        wr_entry(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      for (int r = 0; r < 8; r++) regs[r] = DATA_W'($urandom_range(0, 3));
      run_test($sformatf("rnd%0d", k), int'($urandom_range(0, 24)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
